// File: rtl/axi_burst_pkg.sv
// Shared constants and state encodings for the AXI burst master.
// Holds response/burst codes and the write/read engine state enums.
package axi_burst_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ADDR,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/axi_burst_chunker.sv
// Combinational burst sizer: beats for the next INCR burst.
// Ports: addr (aligned byte address), remaining (beats left) -> chunk.
module axi_burst_chunker
   import axi_burst_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [CNT_WIDTH-1:0]  remaining,
   output logic [8:0]            chunk
);

   localparam int SIZE = $clog2(DATA_WIDTH / 8);

   logic [12:0] room;
   logic [31:0] c;
   logic        unused_bits;

   // beats left before the next 4KB page boundary
   assign room = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;

   always_comb begin
      c = 32'(remaining);
      if (c > 32'(MAX_BURST)) c = 32'(MAX_BURST);
      if (c > 32'(room))      c = 32'(room);
   end

   assign chunk       = c[8:0];
   assign unused_bits = ^{addr[ADDR_WIDTH-1:12], c[31:9]};

endmodule

// File: rtl/axi_burst_master_split.sv
// AXI4 master splitting long commands into legal INCR bursts.
// Ports: wr/rd command + data streams, done/err status, AXI4 AW/W/B/AR/R.
module axi_burst_master_split
   import axi_burst_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int AXI_ID     = 0,
   parameter int MAX_BURST  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_cmd_valid,
   output logic                    wr_cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   wr_cmd_addr,
   input  logic [CNT_WIDTH-1:0]    wr_cmd_beats,
   input  logic                    wr_data_valid,
   output logic                    wr_data_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   output logic                    wr_done,
   output logic                    wr_err,
   input  logic                    rd_cmd_valid,
   output logic                    rd_cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   rd_cmd_addr,
   input  logic [CNT_WIDTH-1:0]    rd_cmd_beats,
   output logic                    rd_data_valid,
   input  logic                    rd_data_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    rd_done,
   output logic                    rd_err,
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ID_WIDTH-1:0]     arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_WIDTH-1:0]     rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(BYTES - 1);

   wr_state_t             ws;
   logic [ADDR_WIDTH-1:0] waddr, wnext_addr, wc_addr;
   logic [CNT_WIDTH-1:0]  wrem, wnext_rem, wc_rem;
   logic [8:0]            wchunk, wcnt, wc_chunk;

   rd_state_t             rs;
   logic [ADDR_WIDTH-1:0] raddr, rnext_addr, rc_addr;
   logic [CNT_WIDTH-1:0]  rrem, rnext_rem, rc_rem;
   logic [8:0]            rchunk, rcnt, rc_chunk;
   logic                  rlast_exp;
   logic                  unused_ids;

   assign awid    = ID_WIDTH'(AXI_ID);
   assign arid    = ID_WIDTH'(AXI_ID);
   assign awsize  = 3'(SIZE);
   assign arsize  = 3'(SIZE);
   assign awburst = BURST_INCR;
   assign arburst = BURST_INCR;
   assign awaddr  = waddr;
   assign araddr  = raddr;
   assign unused_ids = ^{bid, rid};

   // chunker sees the new command while idle, else the post-burst position
   assign wnext_addr = waddr + (ADDR_WIDTH'(wchunk) << SIZE);
   assign wnext_rem  = wrem - CNT_WIDTH'(wchunk);
   assign wc_addr    = (ws == W_IDLE) ? (wr_cmd_addr & AMASK) : wnext_addr;
   assign wc_rem     = (ws == W_IDLE) ? wr_cmd_beats : wnext_rem;

   assign rnext_addr = raddr + (ADDR_WIDTH'(rchunk) << SIZE);
   assign rnext_rem  = rrem - CNT_WIDTH'(rchunk);
   assign rc_addr    = (rs == R_IDLE) ? (rd_cmd_addr & AMASK) : rnext_addr;
   assign rc_rem     = (rs == R_IDLE) ? rd_cmd_beats : rnext_rem;

   axi_burst_chunker #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .MAX_BURST(MAX_BURST), .CNT_WIDTH(CNT_WIDTH)
   ) u_wr_chunk (
      .addr(wc_addr), .remaining(wc_rem), .chunk(wc_chunk)
   );

   axi_burst_chunker #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .MAX_BURST(MAX_BURST), .CNT_WIDTH(CNT_WIDTH)
   ) u_rd_chunk (
      .addr(rc_addr), .remaining(rc_rem), .chunk(rc_chunk)
   );

   assign wvalid        = (ws == W_DATA) && wr_data_valid;
   assign wr_data_ready = (ws == W_DATA) && wready;
   assign wlast         = (ws == W_DATA) && (wcnt == wchunk - 9'd1);
   assign wdata         = wr_data;
   assign wstrb         = wr_strb;

   assign rlast_exp     = (rcnt == rchunk - 9'd1);
   assign rd_data_valid = (rs == R_DATA) && rvalid;
   assign rready        = (rs == R_DATA) && rd_data_ready;
   assign rd_data       = rdata;
   assign rd_last       = (rs == R_DATA) && rlast_exp && (rnext_rem == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws           <= W_IDLE;
         wr_cmd_ready <= 1'b0;
         waddr        <= '0;
         wrem         <= '0;
         wchunk       <= '0;
         wcnt         <= '0;
         awlen        <= '0;
         awvalid      <= 1'b0;
         bready       <= 1'b0;
         wr_done      <= 1'b0;
         wr_err       <= 1'b0;
      end else begin
         wr_done <= 1'b0;
         unique case (ws)
            W_IDLE: begin
               wr_cmd_ready <= 1'b1;
               if (wr_cmd_valid && wr_cmd_ready) begin
                  waddr  <= wc_addr;
                  wrem   <= wr_cmd_beats;
                  wr_err <= 1'b0;
                  if (wr_cmd_beats == '0) begin
                     wr_done <= 1'b1;
                  end else begin
                     wr_cmd_ready <= 1'b0;
                     wchunk       <= wc_chunk;
                     awlen        <= 8'(wc_chunk - 9'd1);
                     awvalid      <= 1'b1;
                     ws           <= W_ADDR;
                  end
               end
            end
            W_ADDR: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  wcnt    <= '0;
                  ws      <= W_DATA;
               end
            end
            W_DATA: begin
               if (wvalid && wready) begin
                  if (wlast) begin
                     wcnt   <= '0;
                     bready <= 1'b1;
                     ws     <= W_RESP;
                  end else begin
                     wcnt <= wcnt + 9'd1;
                  end
               end
            end
            W_RESP: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  if (bresp != RESP_OKAY) wr_err <= 1'b1;
                  waddr <= wnext_addr;
                  wrem  <= wnext_rem;
                  if (wnext_rem == '0) begin
                     wr_done      <= 1'b1;
                     wr_cmd_ready <= 1'b1;
                     ws           <= W_IDLE;
                  end else begin
                     wchunk  <= wc_chunk;
                     awlen   <= 8'(wc_chunk - 9'd1);
                     awvalid <= 1'b1;
                     ws      <= W_ADDR;
                  end
               end
            end
            default: ws <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs           <= R_IDLE;
         rd_cmd_ready <= 1'b0;
         raddr        <= '0;
         rrem         <= '0;
         rchunk       <= '0;
         rcnt         <= '0;
         arlen        <= '0;
         arvalid      <= 1'b0;
         rd_done      <= 1'b0;
         rd_err       <= 1'b0;
      end else begin
         rd_done <= 1'b0;
         unique case (rs)
            R_IDLE: begin
               rd_cmd_ready <= 1'b1;
               if (rd_cmd_valid && rd_cmd_ready) begin
                  raddr  <= rc_addr;
                  rrem   <= rd_cmd_beats;
                  rd_err <= 1'b0;
                  if (rd_cmd_beats == '0) begin
                     rd_done <= 1'b1;
                  end else begin
                     rd_cmd_ready <= 1'b0;
                     rchunk       <= rc_chunk;
                     arlen        <= 8'(rc_chunk - 9'd1);
                     arvalid      <= 1'b1;
                     rs           <= R_ADDR;
                  end
               end
            end
            R_ADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rcnt    <= '0;
                  rs      <= R_DATA;
               end
            end
            R_DATA: begin
               if (rvalid && rready) begin
                  // burst length is owned by our counter, rlast is only checked
                  if (rresp != RESP_OKAY || rlast != rlast_exp) rd_err <= 1'b1;
                  if (rlast_exp) begin
                     rcnt  <= '0;
                     raddr <= rnext_addr;
                     rrem  <= rnext_rem;
                     if (rnext_rem == '0) begin
                        rd_done      <= 1'b1;
                        rd_cmd_ready <= 1'b1;
                        rs           <= R_IDLE;
                     end else begin
                        rchunk  <= rc_chunk;
                        arlen   <= 8'(rc_chunk - 9'd1);
                        arvalid <= 1'b1;
                        rs      <= R_ADDR;
                     end
                  end else begin
                     rcnt <= rcnt + 9'd1;
                  end
               end
            end
            default: rs <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_master_split.sv
// Directed bench for axi_burst_master_split with a simple AXI slave.
// Slave logs AW/AR bursts and checks wlast/data; tasks check results.
module tb_axi_burst_master_split;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_cmd_valid = 1'b0, wr_cmd_ready;
   logic [31:0] wr_cmd_addr = '0;
   logic [15:0] wr_cmd_beats = '0;
   logic        wr_data_valid = 1'b1, wr_data_ready;
   logic [31:0] wr_data = 32'h1234_5678;
   logic [3:0]  wr_strb = 4'hF;
   logic        wr_done, wr_err;
   logic        rd_cmd_valid = 1'b0, rd_cmd_ready;
   logic [31:0] rd_cmd_addr = '0;
   logic [15:0] rd_cmd_beats = '0;
   logic        rd_data_valid, rd_data_ready = 1'b1;
   logic [31:0] rd_data;
   logic        rd_last, rd_done, rd_err;
   logic [3:0]  awid, arid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, arvalid;
   logic        awready = 1'b1, wready = 1'b1, arready = 1'b1;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, bready, rready;
   logic [3:0]  bid = '0, rid = '0;
   logic [1:0]  bresp, rresp;
   logic        bvalid, rvalid, rlast;
   logic [31:0] rdata;

   int npass = 0, ntot = 0;

   axi_burst_master_split dut (
      .clk(clk), .reset(reset),
      .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
      .wr_cmd_addr(wr_cmd_addr), .wr_cmd_beats(wr_cmd_beats),
      .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
      .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_done(wr_done), .wr_err(wr_err),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
      .rd_cmd_addr(rd_cmd_addr), .rd_cmd_beats(rd_cmd_beats),
      .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
      .rd_data(rd_data), .rd_last(rd_last),
      .rd_done(rd_done), .rd_err(rd_err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   // slave write side
   int          aw_cnt = 0, wbeat = 0, wbeat_tot = 0, wlast_tot = 0;
   int          wlast_bad = 0, wdata_bad = 0, b_idx = 0, err_idx = -1;
   logic [31:0] aw_addr_log [64];
   logic [7:0]  aw_len_log [64];
   logic [7:0]  cur_wlen = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bvalid <= 1'b0;
         bresp  <= 2'b00;
         wbeat  <= 0;
      end else begin
         if (awvalid && awready) begin
            aw_addr_log[aw_cnt] <= awaddr;
            aw_len_log[aw_cnt]  <= awlen;
            cur_wlen <= awlen;
            aw_cnt   <= aw_cnt + 1;
         end
         if (wvalid && wready) begin
            wbeat_tot <= wbeat_tot + 1;
            if (wdata !== wr_data || wstrb !== wr_strb) wdata_bad <= wdata_bad + 1;
            if (wlast !== (wbeat == int'(cur_wlen))) wlast_bad <= wlast_bad + 1;
            if (wlast) begin
               wlast_tot <= wlast_tot + 1;
               wbeat  <= 0;
               bvalid <= 1'b1;
               bresp  <= (b_idx == err_idx) ? 2'b10 : 2'b00;
            end else begin
               wbeat <= wbeat + 1;
            end
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            b_idx  <= b_idx + 1;
         end
      end
   end

   // slave read side
   int          ar_cnt = 0, rbeat = 0;
   logic [31:0] ar_addr_log [64];
   logic [7:0]  ar_len_log [64];
   logic [7:0]  rlen = '0;
   logic [31:0] rseq = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid <= 1'b0;
         rlast  <= 1'b0;
         rresp  <= 2'b00;
         rdata  <= '0;
         rbeat  <= 0;
      end else if (arvalid && arready) begin
         ar_addr_log[ar_cnt] <= araddr;
         ar_len_log[ar_cnt]  <= arlen;
         ar_cnt <= ar_cnt + 1;
         rvalid <= 1'b1;
         rbeat  <= 0;
         rlen   <= arlen;
         rlast  <= (arlen == 8'd0);
         rdata  <= rseq;
      end else if (rvalid && rready) begin
         rseq <= rseq + 1;
         if (rlast) begin
            rvalid <= 1'b0;
         end else begin
            rbeat <= rbeat + 1;
            rlast <= (rbeat + 1 == int'(rlen));
            rdata <= rseq + 1;
         end
      end
   end

   // user-side observers
   int          wd_cnt = 0, rdn_cnt = 0, rbeats_tot = 0;
   int          rlast_cnt = 0, rlast_pos = 0, rdata_bad = 0;
   logic [31:0] exp_rd = '0;

   always @(posedge clk) begin
      if (wr_done) wd_cnt++;
      if (rd_done) rdn_cnt++;
      if (rd_data_valid && rd_data_ready) begin
         rbeats_tot++;
         if (rd_data !== exp_rd) rdata_bad++;
         exp_rd++;
         if (rd_last) begin
            rlast_cnt++;
            rlast_pos = rbeats_tot;
         end
      end
   end

   task automatic wr_cmd(input logic [31:0] a, input logic [15:0] n);
      @(negedge clk);
      wr_cmd_valid = 1'b1;
      wr_cmd_addr  = a;
      wr_cmd_beats = n;
      for (int i = 0; i < 50 && !wr_cmd_ready; i++) @(negedge clk);
      @(negedge clk);
      wr_cmd_valid = 1'b0;
   endtask

   task automatic rd_cmd(input logic [31:0] a, input logic [15:0] n);
      @(negedge clk);
      rd_cmd_valid = 1'b1;
      rd_cmd_addr  = a;
      rd_cmd_beats = n;
      for (int i = 0; i < 50 && !rd_cmd_ready; i++) @(negedge clk);
      @(negedge clk);
      rd_cmd_valid = 1'b0;
   endtask

   task automatic wait_wd(input int target);
      for (int i = 0; i < 500 && wd_cnt < target; i++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_rd(input int target);
      for (int i = 0; i < 500 && rdn_cnt < target; i++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [9:0] v;
      repeat (3) @(negedge clk);
      v = {wr_cmd_ready, rd_cmd_ready, awvalid, arvalid, wvalid,
           bready, rready, wr_done, rd_done, wr_err};
      ntot++;
      if (v !== 10'b0) $display("FAIL reset_ctrl got %b want 0", v);
      else npass++;
      ntot++;
      if ({awaddr, awlen, araddr, arlen} !== 80'b0)
         $display("FAIL reset_addr got %h/%h want 0", awaddr, awlen);
      else npass++;
      reset = 1'b0;
      @(negedge clk);
      ntot++;
      if ({wr_cmd_ready, rd_cmd_ready} !== 2'b11)
         $display("FAIL reset_ready got %b want 11", {wr_cmd_ready, rd_cmd_ready});
      else npass++;
   endtask

   task automatic test_single_burst;
      int a0 = aw_cnt, d0 = wd_cnt, w0 = wbeat_tot, l0 = wlast_tot;
      wr_cmd(32'h0, 16'd8);
      wait_wd(d0 + 1);
      ntot++;
      if (aw_cnt - a0 !== 1) $display("FAIL t1_aw_count got %0d want 1", aw_cnt - a0);
      else npass++;
      ntot++;
      if (aw_len_log[a0] !== 8'd7 || aw_addr_log[a0] !== 32'h0)
         $display("FAIL t1_aw got %h@%h want 07@0", aw_len_log[a0], aw_addr_log[a0]);
      else npass++;
      ntot++;
      if ({awsize, awburst, awid} !== {3'd2, 2'b01, 4'd0})
         $display("FAIL t1_consts got %h/%h/%h want 2/1/0", awsize, awburst, awid);
      else npass++;
      ntot++;
      if (wbeat_tot - w0 !== 8 || wlast_tot - l0 !== 1)
         $display("FAIL t1_beats got %0d/%0d want 8/1", wbeat_tot - w0, wlast_tot - l0);
      else npass++;
      ntot++;
      if (wd_cnt - d0 !== 1) $display("FAIL t1_done got %0d want 1", wd_cnt - d0);
      else npass++;
   endtask

   task automatic test_split_write;
      int a0 = aw_cnt, d0 = wd_cnt, w0 = wbeat_tot;
      wr_cmd(32'h0, 16'd40);
      wait_wd(d0 + 1);
      ntot++;
      if (aw_cnt - a0 !== 3) $display("FAIL t2_aw_count got %0d want 3", aw_cnt - a0);
      else npass++;
      ntot++;
      if ({aw_len_log[a0], aw_len_log[a0+1], aw_len_log[a0+2]} !== 24'h0F0F07)
         $display("FAIL t2_lens got %h %h %h want 0f 0f 07",
                  aw_len_log[a0], aw_len_log[a0+1], aw_len_log[a0+2]);
      else npass++;
      ntot++;
      if ({aw_addr_log[a0], aw_addr_log[a0+1], aw_addr_log[a0+2]} !==
          {32'h0, 32'h40, 32'h80})
         $display("FAIL t2_addrs got %h %h %h want 0 40 80",
                  aw_addr_log[a0], aw_addr_log[a0+1], aw_addr_log[a0+2]);
      else npass++;
      ntot++;
      if (wbeat_tot - w0 !== 40 || wd_cnt - d0 !== 1)
         $display("FAIL t2_beats_done got %0d/%0d want 40/1", wbeat_tot - w0, wd_cnt - d0);
      else npass++;
      ntot++;
      if (wlast_bad !== 0 || wdata_bad !== 0)
         $display("FAIL t2_wstream got %0d/%0d want 0/0", wlast_bad, wdata_bad);
      else npass++;
   endtask

   task automatic test_read_4k;
      int a0 = ar_cnt, d0 = rdn_cnt, b0 = rbeats_tot, l0 = rlast_cnt;
      rd_cmd(32'hFF8, 16'd6);
      wait_rd(d0 + 1);
      ntot++;
      if (ar_cnt - a0 !== 2) $display("FAIL t3_ar_count got %0d want 2", ar_cnt - a0);
      else npass++;
      ntot++;
      if (ar_len_log[a0] !== 8'd1 || ar_addr_log[a0] !== 32'hFF8)
         $display("FAIL t3_ar0 got %h@%h want 01@ff8", ar_len_log[a0], ar_addr_log[a0]);
      else npass++;
      ntot++;
      if (ar_len_log[a0+1] !== 8'd3 || ar_addr_log[a0+1] !== 32'h1000)
         $display("FAIL t3_ar1 got %h@%h want 03@1000", ar_len_log[a0+1], ar_addr_log[a0+1]);
      else npass++;
      ntot++;
      if (rbeats_tot - b0 !== 6 || rlast_cnt - l0 !== 1 || rlast_pos - b0 !== 6)
         $display("FAIL t3_rd_last got %0d/%0d/%0d want 6/1/6",
                  rbeats_tot - b0, rlast_cnt - l0, rlast_pos - b0);
      else npass++;
      ntot++;
      if (rdn_cnt - d0 !== 1 || rd_err !== 1'b0 || rdata_bad !== 0)
         $display("FAIL t3_done got %0d/%b/%0d want 1/0/0", rdn_cnt - d0, rd_err, rdata_bad);
      else npass++;
   endtask

   task automatic test_slverr;
      int a0 = aw_cnt, d0 = wd_cnt;
      err_idx = b_idx + 1;
      wr_cmd(32'h0, 16'd40);
      wait_wd(d0 + 1);
      ntot++;
      if (wr_err !== 1'b1) $display("FAIL t4_err got %b want 1", wr_err);
      else npass++;
      ntot++;
      if (aw_cnt - a0 !== 3 || wd_cnt - d0 !== 1)
         $display("FAIL t4_bursts got %0d/%0d want 3/1", aw_cnt - a0, wd_cnt - d0);
      else npass++;
      err_idx = -1;
      wr_cmd(32'h300, 16'd4);
      ntot++;
      if (wr_err !== 1'b0) $display("FAIL t4_err_clear got %b want 0", wr_err);
      else npass++;
      wait_wd(d0 + 2);
      ntot++;
      if (wr_err !== 1'b0 || wd_cnt - d0 !== 2)
         $display("FAIL t4_next got %b/%0d want 0/2", wr_err, wd_cnt - d0);
      else npass++;
   endtask

   task automatic test_zero_beats;
      int a0 = aw_cnt, r0 = ar_cnt;
      @(negedge clk);
      wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h40; wr_cmd_beats = 16'd0;
      rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h40; rd_cmd_beats = 16'd0;
      @(negedge clk);
      ntot++;
      if ({wr_done, rd_done, awvalid, arvalid} !== 4'b1100)
         $display("FAIL t5_pulse got %b want 1100", {wr_done, rd_done, awvalid, arvalid});
      else npass++;
      wr_cmd_valid = 1'b0;
      rd_cmd_valid = 1'b0;
      @(negedge clk);
      ntot++;
      if ({wr_done, rd_done, awvalid, arvalid} !== 4'b0000)
         $display("FAIL t5_after got %b want 0000", {wr_done, rd_done, awvalid, arvalid});
      else npass++;
      ntot++;
      if (aw_cnt - a0 !== 0 || ar_cnt - r0 !== 0)
         $display("FAIL t5_traffic got %0d/%0d want 0/0", aw_cnt - a0, ar_cnt - r0);
      else npass++;
   endtask

   task automatic test_mid_reset;
      int w0 = wbeat_tot, d0, a0;
      logic [11:0] v;
      wr_cmd(32'h100, 16'd8);
      for (int i = 0; i < 50 && wbeat_tot - w0 < 2; i++) @(negedge clk);
      reset = 1'b1;
      #1;
      v = {awvalid, wvalid, wr_data_valid & wr_data_ready, bready, wlast,
           wr_cmd_ready, rd_cmd_ready, wr_done, rd_done, wr_err, arvalid, rready};
      ntot++;
      if (v !== 12'b0010_0000_0000 && v !== 12'b0)
         $display("FAIL t6_ctrl got %b want 0", v);
      else npass++;
      ntot++;
      if ({wvalid, wr_data_ready, awaddr, awlen} !== 42'b0)
         $display("FAIL t6_addr got %h/%h want 0", awaddr, awlen);
      else npass++;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      d0 = wd_cnt;
      a0 = aw_cnt;
      wr_cmd(32'h200, 16'd4);
      wait_wd(d0 + 1);
      ntot++;
      if (wd_cnt - d0 !== 1 || aw_cnt - a0 !== 1)
         $display("FAIL t6_recover got %0d/%0d want 1/1", wd_cnt - d0, aw_cnt - a0);
      else npass++;
      ntot++;
      if (aw_addr_log[a0] !== 32'h200 || aw_len_log[a0] !== 8'd3 || wlast_bad !== 0)
         $display("FAIL t6_burst got %h@%h/%0d want 03@200/0",
                  aw_len_log[a0], aw_addr_log[a0], wlast_bad);
      else npass++;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_split_write();
      test_read_4k();
      test_slverr();
      test_zero_beats();
      test_mid_reset();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
